// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator sweep driver: FSM state encoding
// and the bit positions of the GT/EQ/LT flags inside a 3-bit flag vector.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

endpackage

// File: rtl/cmp_expect.sv
// Combinational reference comparator: expected unsigned GT/EQ/LT flags for a
// pair of operands, packed at the CMP_* bit positions.
module cmp_expect
  import cmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [2:0]       flags_o
);

  always_comb begin
    flags_o         = '0;
    flags_o[CMP_GT] = (a_i > b_i);
    flags_o[CMP_EQ] = (a_i == b_i);
    flags_o[CMP_LT] = (a_i < b_i);
  end

endmodule

// File: rtl/cmp_sweep_driver.sv
// Sweeps every operand pair through an external comparator and counts wrong answers.
// Optional macro CMP_SWEEP_TIMEOUT_EN abandons a pair after TIMEOUT cycles without ACK.
module cmp_sweep_driver
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               START,
  output logic [WIDTH-1:0]   OP_A,
  output logic [WIDTH-1:0]   OP_B,
  output logic               REQ,
  input  logic               ACK,
  input  logic               GT_IN,
  input  logic               EQ_IN,
  input  logic               LT_IN,
  output logic               BUSY,
  output logic               DONE,
  output logic               PASS,
  output logic [2*WIDTH:0]   ERR_CNT
);

  localparam int IDX_W = 2 * WIDTH;
  localparam int ERR_W = 2 * WIDTH + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               done_q, done_d;
  logic [2:0]         exp_flags, got_flags;
  logic               xfer, tmo, adv, miss;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  cmp_expect #(.WIDTH(WIDTH)) u_expect (
    .a_i     (OP_A),
    .b_i     (OP_B),
    .flags_o (exp_flags)
  );

`ifdef CMP_SWEEP_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [WAIT_W-1:0] wait_q, wait_d;

  // Counter is zero on every DRIVE entry and after every transfer or timeout.
  always_comb begin
    tmo    = (state_q == DRIVE) && !ACK && (wait_q == WAIT_W'(TIMEOUT - 1));
    wait_d = '0;
    if ((state_q == DRIVE) && !ACK && !tmo) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    done_d    = done_q;
    got_flags = '0;
    got_flags[CMP_GT] = GT_IN;
    got_flags[CMP_EQ] = EQ_IN;
    got_flags[CMP_LT] = LT_IN;
    xfer = (state_q == DRIVE) && ACK;
    adv  = xfer || tmo;
    miss = (xfer && (got_flags != exp_flags)) || tmo;
    unique case (state_q)
      IDLE: if (START) begin
        idx_d   = '0;
        err_d   = '0;
        done_d  = 1'b0;
        state_d = DRIVE;
      end
      DRIVE: if (adv) begin
        if (miss) err_d = sat_inc(err_q);
        state_d = (idx_q == '1) ? FINISH : GAP;
      end
      GAP: begin
        idx_d   = idx_q + 1'b1;
        state_d = DRIVE;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign OP_A    = idx_q[IDX_W-1:WIDTH];
  assign OP_B    = idx_q[WIDTH-1:0];
  assign REQ     = (state_q == DRIVE);
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign PASS    = done_q && (err_q == '0);
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Directed/randomized bench for cmp_sweep_driver (WIDTH=2, TIMEOUT=15) with a
// behavioural responder and an arithmetic model of expected error counts and latency.
module tb_cmp_sweep_driver;
  import cmp_pkg::*;

  localparam int W   = 2;
  localparam int N   = 16;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           RESET, START, ACK, GT_IN, EQ_IN, LT_IN;
  logic [W-1:0]   OP_A, OP_B;
  logic           REQ, BUSY, DONE, PASS;
  logic [2*W:0]   ERR_CNT;
  logic [W-1:0]   ea, eb;
  logic [2:0]     eflags;

  int checks = 0;
  int errors = 0;
  int ack_mode = 0;
  int flag_mode = 0;
  logic [2:0] rnd_flags [N];
  logic ack_q = 1'b0;
  logic ack_rnd = 1'b0;
  int xfer_total = 0;
  bit mon_en = 1'b0;
  logic prev_req = 1'b0;
  logic prev_xfer = 1'b0;
  logic [2*W-1:0] prev_op = '0;

  always #5 clk = ~clk;

  cmp_sweep_driver #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .CLOCK_50 (clk),
    .RESET    (RESET),
    .START    (START),
    .OP_A     (OP_A),
    .OP_B     (OP_B),
    .REQ      (REQ),
    .ACK      (ACK),
    .GT_IN    (GT_IN),
    .EQ_IN    (EQ_IN),
    .LT_IN    (LT_IN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PASS     (PASS),
    .ERR_CNT  (ERR_CNT)
  );

  cmp_expect #(.WIDTH(W)) u_exp (.a_i(ea), .b_i(eb), .flags_o(eflags));

  // Responder: flags and ACK policy selected by the directed sequence.
  always_comb begin
    {GT_IN, EQ_IN, LT_IN} = {OP_A > OP_B, OP_A == OP_B, OP_A < OP_B};
    if (flag_mode == 1)      {GT_IN, EQ_IN, LT_IN} = 3'b100;
    else if (flag_mode == 2) {GT_IN, EQ_IN, LT_IN} = rnd_flags[{OP_A, OP_B}];
    case (ack_mode)
      0:       ACK = 1'b1;
      1:       ACK = ack_q;
      2:       ACK = ack_rnd & REQ;
      default: ACK = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    ack_q <= REQ && !ack_q;
    if (REQ && ACK) xfer_total <= xfer_total + 1;
  end

  always @(negedge clk) ack_rnd = 1'($urandom_range(0, 1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Operands must hold while REQ waits for ACK.
  always @(negedge clk) begin
    if (mon_en && REQ && prev_req && !prev_xfer) chk("op_stable", {OP_A, OP_B}, prev_op);
    prev_req  = REQ;
    prev_xfer = REQ && ACK;
    prev_op   = {OP_A, OP_B};
  end

  function automatic int model_errs(input int fm);
    int e = 0;
    logic [2:0] ex, r;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        ex = {a > b, a == b, a < b};
        r  = (fm == 0) ? ex : (fm == 1) ? 3'b100 : rnd_flags[a * (1 << W) + b];
        if (r != ex) e++;
      end
    return e;
  endfunction

  task automatic start_sweep();
    @(negedge clk); START = 1'b1;
    @(negedge clk); START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (DONE !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (DONE !== 1'b1) chk("done_bound", 32'(DONE), 1);
  endtask

  initial begin
    int cyc, x0, me;
    logic [2:0] ex;
    RESET = 1'b1; START = 1'b0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    chk("rst_opa", 32'(OP_A), 0);
    chk("rst_opb", 32'(OP_B), 0);
    chk("rst_req", 32'(REQ), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_pass", 32'(PASS), 0);
    chk("rst_err", 32'(ERR_CNT), 0);

    for (int i = 0; i < N; i++) begin
      ea = W'(i >> W); eb = W'(i);
      #1;
      ex = '0;
      ex[CMP_GT] = (i >> W) > (i % (1 << W));
      ex[CMP_EQ] = (i >> W) == (i % (1 << W));
      ex[CMP_LT] = (i >> W) < (i % (1 << W));
      chk("expect_flags", 32'(eflags), 32'(ex));
    end

    // Correct responder, ACK tied high.
    x0 = xfer_total;
    start_sweep();
    chk("start_busy", 32'(BUSY), 1);
    chk("start_req", 32'(REQ), 1);
    chk("start_op", 32'({OP_A, OP_B}), 0);
    wait_done(2000, cyc);
    chk("lat_ackhigh", cyc, 1 + N * 2);
    chk("ok_pass", 32'(PASS), 1);
    chk("ok_err", 32'(ERR_CNT), 32'(model_errs(0)));
    chk("ok_busy", 32'(BUSY), 0);
    chk("ok_xfers", xfer_total - x0, N);

    // ACK and bad flags while idle must not disturb the result.
    flag_mode = 1;
    repeat (5) @(negedge clk);
    chk("idle_err", 32'(ERR_CNT), 0);
    chk("idle_done", 32'(DONE), 1);

    // Responder always answers GT.
    start_sweep();
    chk("restart_done_clr", 32'(DONE), 0);
    wait_done(2000, cyc);
    chk("gt_err", 32'(ERR_CNT), 32'(model_errs(1)));
    chk("gt_err_const", 32'(ERR_CNT), 10);
    chk("gt_pass", 32'(PASS), 0);

    // ACK one cycle after REQ rises; operands watched for stability.
    flag_mode = 0; ack_mode = 1; mon_en = 1'b1;
    start_sweep();
    wait_done(2000, cyc);
    mon_en = 1'b0;
    chk("lat_ackdly", cyc, 1 + N * 3);
    chk("dly_err", 32'(ERR_CNT), 0);
    chk("dly_pass", 32'(PASS), 1);

    // Random flag tables with random ACK timing.
    flag_mode = 2; ack_mode = 2;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) rnd_flags[i] = 3'($urandom_range(0, 7));
      me = model_errs(2);
      x0 = xfer_total;
      start_sweep();
      wait_done(4000, cyc);
      chk("rnd_err", 32'(ERR_CNT), 32'(me));
      chk("rnd_pass", 32'(PASS), 32'(me == 0));
      chk("rnd_xfers", xfer_total - x0, N);
    end

    // Reset during the 5th transfer abandons the sweep.
    flag_mode = 1; ack_mode = 0;
    start_sweep();
    repeat (8) @(negedge clk);
    chk("pre_rst_idx", 32'({OP_A, OP_B}), 4);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    chk("mid_rst_outs", 32'({OP_A, OP_B, REQ, BUSY, DONE, PASS}), 0);
    chk("mid_rst_err", 32'(ERR_CNT), 0);
    repeat (40) @(negedge clk);
    chk("abandon_done", 32'(DONE), 0);
    chk("abandon_busy", 32'(BUSY), 0);
    flag_mode = 0;
    start_sweep();
    chk("resweep_op", 32'({OP_A, OP_B}), 0);
    wait_done(2000, cyc);
    chk("resweep_err", 32'(ERR_CNT), 0);
    chk("resweep_lat", cyc, 1 + N * 2);

    // START held high for the whole sweep.
    x0 = xfer_total;
    @(negedge clk); START = 1'b1;
    @(negedge clk);
    wait_done(2000, cyc);
    chk("held_lat", cyc, 1 + N * 2);
    chk("held_xfers", xfer_total - x0, N);
    chk("held_idle_busy", 32'(BUSY), 0);
    chk("held_pass", 32'(PASS), 1);
    @(negedge clk);
    chk("held_restart_done", 32'(DONE), 0);
    chk("held_restart_busy", 32'(BUSY), 1);
    chk("held_restart_op", 32'({OP_A, OP_B}), 0);
    START = 1'b0; RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;

`ifdef CMP_SWEEP_TIMEOUT_EN
    // No responder: each pair times out.
    ack_mode = 3;
    start_sweep();
    wait_done(1000, cyc);
    chk("tmo_lat", cyc, 1 + N * (TMO + 1));
    chk("tmo_err", 32'(ERR_CNT), N);
    chk("tmo_pass", 32'(PASS), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_sweep_driver.md
CMP_SWEEP_DRIVER -- requirements
Module: cmp_sweep_driver

Interface
REQ-001 Parameter WIDTH, default 2, operand width in bits; legal range 1..8.
REQ-002 Parameter TIMEOUT, default 15, number of ACK wait cycles before a transfer is abandoned; used only when the timeout feature is compiled in.
REQ-003 CLOCK_50  input  1  single clock; all logic updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 START  input  1  starts a sweep; sampled high only in IDLE.
REQ-006 OP_A  output  WIDTH  operand A presented to the comparator under test.
REQ-007 OP_B  output  WIDTH  operand B presented to the comparator under test.
REQ-008 REQ  output  1  operands valid; the comparator under test must answer.
REQ-009 ACK  input  1  responder accepts the operands and GT_IN/EQ_IN/LT_IN are valid.
REQ-010 GT_IN, EQ_IN, LT_IN  input  1 each  comparator result flags.
REQ-011 BUSY  output  1  sweep in progress.
REQ-012 DONE  output  1  sweep complete; held until the next START or RESET.
REQ-013 PASS  output  1  DONE with ERR_CNT equal to 0.
REQ-014 ERR_CNT  output  2*WIDTH+1  count of failed transfers; saturates at all-ones.

Function
REQ-015 The FSM has four states: IDLE, DRIVE, GAP and FINISH.
REQ-016 In IDLE, a high START loads the pair index with 0, clears ERR_CNT and DONE, and moves the FSM to DRIVE on the next edge.
REQ-017 The pair index is 2*WIDTH bits wide; OP_A is the upper WIDTH bits of the index and OP_B is the lower WIDTH bits.
REQ-018 In DRIVE, REQ is high and OP_A/OP_B remain stable until a cycle in which REQ and ACK are both high (a transfer).
REQ-019 In the transfer cycle, the flags are checked against the expected values GT=(A>B), EQ=(A==B) and LT=(A<B), all unsigned.
REQ-020 Any flag mismatch increments ERR_CNT by one; this includes a result that is not one-hot.
REQ-021 After a transfer, the FSM moves to GAP for exactly one cycle with REQ low, then returns to DRIVE with the index incremented.
REQ-022 A transfer at index all-ones moves the FSM to FINISH instead of GAP; the index does not wrap.
REQ-023 FINISH lasts one cycle, then the FSM enters IDLE with DONE high and PASS=(ERR_CNT==0).
REQ-024 Full sweep length is 2^(2*WIDTH) transfers; minimum latency from START to DONE is 2*2^(2*WIDTH)+1 cycles.
REQ-025 BUSY is high in DRIVE, GAP and FINISH.
REQ-026 START outside IDLE is ignored.
REQ-027 ACK outside DRIVE is ignored and has no effect on ERR_CNT.
REQ-028 START and a high DONE in the same cycle: the new sweep starts and DONE clears on that edge.

Reset
REQ-029 RESET is synchronous and active-high, and takes priority over all other inputs.
REQ-030 Reset values: FSM in IDLE; OP_A=0, OP_B=0, REQ=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0; index=0.
REQ-031 RESET asserted mid-sweep abandons the sweep; DONE is not asserted for the abandoned sweep.

Configuration
REQ-032 With macro CMP_SWEEP_TIMEOUT_EN defined, a wait counter counts DRIVE cycles without a transfer.
REQ-033 With CMP_SWEEP_TIMEOUT_EN defined, reaching TIMEOUT cycles without a transfer increments ERR_CNT and advances the FSM as if a transfer occurred (GAP, or FINISH at the last index).
REQ-034 With CMP_SWEEP_TIMEOUT_EN defined, the wait counter clears on every transfer and every DRIVE entry.
REQ-035 Without CMP_SWEEP_TIMEOUT_EN, no wait counter exists and DRIVE waits for ACK indefinitely.

Structure
REQ-036 The shared package cmp_pkg holds the state enum (IDLE, DRIVE, GAP, FINISH) and the flag-encoding constants CMP_GT, CMP_EQ and CMP_LT.
REQ-037 One sub-module, cmp_expect, computes the expected GT/EQ/LT flags combinationally from OP_A/OP_B.
REQ-038 cmp_expect is reused by the top-level bench to self-check the comparator under test.

Verification (WIDTH=2, TIMEOUT=15)
REQ-039 Correct responder, ACK tied high, START pulse -> 16 transfers, DONE=1 and PASS=1 at cycle 33 after START, ERR_CNT=0.
REQ-040 Responder forcing GT=1 for every pair -> DONE=1, PASS=0, ERR_CNT=10.
REQ-041 Responder drives ACK one cycle after REQ rises -> OP_A/OP_B stay stable while REQ is high; ERR_CNT=0.
REQ-042 RESET asserted at the 5th transfer -> next edge all outputs at reset values; a later START sweeps from index 0.
REQ-043 START held high for the whole sweep -> exactly one sweep runs; a new sweep starts in the first IDLE cycle with DONE=1.
REQ-044 CMP_SWEEP_TIMEOUT_EN defined, ACK held low -> each pair is abandoned after 15 cycles; sweep ends with ERR_CNT=16, PASS=0.
